// File: rtl/bnn_pkg.sv
// ---------------------------------------------------------------------------
// bnn_pkg
// Shared definitions for the BNN accelerator output stage:
//   - default class count, popcount score width and label width
//   - argmax FSM state encoding
//   - class counter width
// ---------------------------------------------------------------------------
package bnn_pkg;

  localparam int NUM_CLASS_DEF = 10;
  localparam int SCORE_W_DEF   = 7;
  localparam int LABEL_W_DEF   = 4;

  // Counter wide enough to index every class; at least one bit.
  localparam int CLS_CNT_W = (NUM_CLASS_DEF > 1) ? $clog2(NUM_CLASS_DEF) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } bnn_state_e;

endpackage : bnn_pkg

// File: rtl/bnn_max_cmp.sv
// ---------------------------------------------------------------------------
// bnn_max_cmp
// Combinational running-maximum step. The incumbent (cur_*) always carries a
// lower class index than the candidate (cand_*), so a strict greater-than
// makes the lowest index win on ties.
// Ports:
//   force_i       take the candidate unconditionally (first class of a run)
//   cur_score_i   incumbent best score      cur_idx_i   incumbent index
//   cand_score_i  candidate score           cand_idx_i  candidate index
//   take_o        candidate replaces incumbent
//   win_score_o   resulting best score      win_idx_o   resulting index
// ---------------------------------------------------------------------------
module bnn_max_cmp #(
  parameter int SCORE_W = 7,
  parameter int IDX_W   = 4
) (
  input  logic               force_i,
  input  logic [SCORE_W-1:0] cur_score_i,
  input  logic [IDX_W-1:0]   cur_idx_i,
  input  logic [SCORE_W-1:0] cand_score_i,
  input  logic [IDX_W-1:0]   cand_idx_i,
  output logic               take_o,
  output logic [SCORE_W-1:0] win_score_o,
  output logic [IDX_W-1:0]   win_idx_o
);

  assign take_o      = force_i || (cand_score_i > cur_score_i);
  assign win_score_o = take_o ? cand_score_i : cur_score_i;
  assign win_idx_o   = take_o ? cand_idx_i   : cur_idx_i;

endmodule : bnn_max_cmp

// File: rtl/bnn_argmax_out.sv
// ---------------------------------------------------------------------------
// bnn_argmax_out
// Output classification stage: consumes one popcount score per class in
// class order, tracks the running argmax, then presents the winning label
// with out_en high (out_en turns the shared data port around at chip top).
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (priority over start)
//   start        one-cycle pulse, clears all state and begins collection
//   score_valid  FC score present on score_in
//   score_in     unsigned popcount of the current class
//   score_ready  high while collecting (decoded from state only)
//   label_out    winning class index (registered)
//   max_score    winning score (registered, debug)
//   out_en       label valid / output direction (registered)
//   err          sticky protocol-violation flag, cleared by rst or start
// ---------------------------------------------------------------------------
module bnn_argmax_out
  import bnn_pkg::*;
#(
  parameter int NUM_CLASS = NUM_CLASS_DEF,
  parameter int SCORE_W   = SCORE_W_DEF,
  parameter int LABEL_W   = LABEL_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               score_valid,
  input  logic [SCORE_W-1:0] score_in,
  output logic               score_ready,
  output logic [LABEL_W-1:0] label_out,
  output logic [SCORE_W-1:0] max_score,
  output logic               out_en,
  output logic               err
);

  localparam int CNT_W = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;
  localparam logic [CNT_W-1:0] LAST_CLS = CNT_W'(NUM_CLASS - 1);

  bnn_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cls_cnt_q, cls_cnt_d;
  logic [LABEL_W-1:0] best_idx_q, best_idx_d;
  logic [SCORE_W-1:0] best_score_q, best_score_d;
  logic               err_q, err_d;
  logic               out_en_q;

  logic               cmp_take;
  logic [SCORE_W-1:0] cmp_score;
  logic [LABEL_W-1:0] cmp_idx;

  // The first accepted class always seeds the maximum, even at score 0.
  bnn_max_cmp #(
    .SCORE_W (SCORE_W),
    .IDX_W   (LABEL_W)
  ) u_cmp (
    .force_i      (cls_cnt_q == '0),
    .cur_score_i  (best_score_q),
    .cur_idx_i    (best_idx_q),
    .cand_score_i (score_in),
    .cand_idx_i   (LABEL_W'(cls_cnt_q)),
    .take_o       (cmp_take),
    .win_score_o  (cmp_score),
    .win_idx_o    (cmp_idx)
  );

  always_comb begin
    state_d      = state_q;
    cls_cnt_d    = cls_cnt_q;
    best_idx_d   = best_idx_q;
    best_score_d = best_score_q;
    err_d        = err_q;

    if (start) begin
      // start wins over everything, including a final score in flight.
      state_d      = ST_COLLECT;
      cls_cnt_d    = '0;
      best_idx_d   = '0;
      best_score_d = '0;
      err_d        = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (score_valid) err_d = 1'b1;
        end
        ST_COLLECT: begin
          if (score_valid) begin
            best_idx_d   = cmp_idx;
            best_score_d = cmp_score;
            if (cls_cnt_q == LAST_CLS) begin
              state_d = ST_DONE;
            end else begin
              cls_cnt_d = cls_cnt_q + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (score_valid) err_d = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cls_cnt_q    <= '0;
      best_idx_q   <= '0;
      best_score_q <= '0;
      err_q        <= 1'b0;
      out_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cls_cnt_q    <= cls_cnt_d;
      best_idx_q   <= best_idx_d;
      best_score_q <= best_score_d;
      err_q        <= err_d;
      // Registered so out_en tracks the DONE state exactly, rising on the
      // edge that accepts the final score and falling as DONE is left.
      out_en_q     <= (state_d == ST_DONE);
    end
  end

  assign score_ready = (state_q == ST_COLLECT);
  assign label_out   = best_idx_q;
  assign max_score   = best_score_q;
  assign out_en      = out_en_q;
  assign err         = err_q;

  // cmp_take is folded into the comparator's select outputs.
  logic unused_take;
  assign unused_take = cmp_take;

endmodule : bnn_argmax_out

// File: tb/tb_bnn_argmax_out.sv
module tb_bnn_argmax_out;

  localparam int NC = 10;
  localparam int SW = 7;
  localparam int LW = 4;

  typedef logic [SW-1:0] set_t [NC];
  typedef struct packed {
    logic [LW-1:0] lbl;
    logic [SW-1:0] mx;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          score_valid = 1'b0;
  logic [SW-1:0] score_in = '0;
  logic          score_ready;
  logic [LW-1:0] label_out;
  logic [SW-1:0] max_score;
  logic          out_en;
  logic          err;

  int vectors = 0;
  int miscompares = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  bnn_argmax_out #(.NUM_CLASS(NC), .SCORE_W(SW), .LABEL_W(LW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .score_valid (score_valid),
    .score_in    (score_in),
    .score_ready (score_ready),
    .label_out   (label_out),
    .max_score   (max_score),
    .out_en      (out_en),
    .err         (err)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference argmax: first index wins on ties.
  function automatic exp_t model(input set_t sc);
    exp_t e;
    e.lbl = '0;
    e.mx  = sc[0];
    for (int i = 1; i < NC; i++) begin
      if (sc[i] > e.mx) begin
        e.mx  = sc[i];
        e.lbl = LW'(i);
      end
    end
    return e;
  endfunction

  task automatic check_idle_outputs(input string name);
    vectors++;
    if ({score_ready, out_en, label_out, max_score, err} !== '0) begin
      miscompares++;
      $display("FAIL %s: ready/out_en/label/max/err = %b/%b/%0d/%0d/%b, required all 0",
               name, score_ready, out_en, label_out, max_score, err);
    end
  endtask

  task automatic do_start(input string name);
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (score_ready !== 1'b1 || out_en !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: after start ready/out_en/err = %b/%b/%b, required 1/0/0",
               name, score_ready, out_en, err);
    end
  endtask

  // Drive the first n scores of sc; optional random bubbles with junk data.
  task automatic send_scores(input string name, input set_t sc, input int n, input bit bubbles);
    for (int i = 0; i < n; i++) begin
      if (bubbles) begin
        int gap = int'($urandom_range(0, 3));
        for (int g = 0; g < gap; g++) begin
          score_valid = 1'b0;
          score_in    = SW'($urandom_range(0, 127));
          tick();
        end
      end
      score_valid = 1'b1;
      score_in    = sc[i];
      vectors++;
      if (score_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL %s ready[%0d]: got %b, required 1", name, i, score_ready);
      end
      tick();
      vectors++;
      if (out_en !== (i == NC - 1)) begin
        miscompares++;
        $display("FAIL %s out_en after score %0d: got %b, required %b",
                 name, i, out_en, (i == NC - 1));
      end
    end
    score_valid = 1'b0;
    score_in    = '0;
  endtask

  task automatic check_result(input string name);
    exp_t e;
    int   waited = 0;
    while (out_en !== 1'b1 && waited < 16) begin
      tick();
      waited++;
    end
    vectors++;
    if (out_en !== 1'b1) begin
      miscompares++;
      $display("FAIL %s timeout: out_en = %b after %0d cycles, required 1", name, out_en, waited);
    end
    if (sb_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s scoreboard: empty, required one entry", name);
    end else begin
      e = sb_q.pop_front();
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (label_out !== e.lbl || max_score !== e.mx || score_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL %s result[%0d]: label=%0d max=%0d ready=%b, required label=%0d max=%0d ready=0",
                   name, k, label_out, max_score, score_ready, e.lbl, e.mx);
        end
        tick();
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_idle_outputs("reset");
  endtask

  task automatic test_basic();
    set_t sc = '{7'd10, 7'd20, 7'd30, 7'd40, 7'd50, 7'd96, 7'd5, 7'd0, 7'd1, 7'd2};
    do_start("basic");
    sb_q.push_back('{lbl: 4'd5, mx: 7'd96});
    send_scores("basic", sc, NC, 1'b0);
    check_result("basic");
  endtask

  task automatic test_tie();
    set_t sc = '{7'd48, 7'd70, 7'd70, 7'd12, 7'd70, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0};
    do_start("tie");
    sb_q.push_back('{lbl: 4'd1, mx: 7'd70});
    send_scores("tie", sc, NC, 1'b0);
    check_result("tie");
  endtask

  task automatic test_zero();
    set_t sc = '{default: 7'd0};
    do_start("zero");
    sb_q.push_back('{lbl: 4'd0, mx: 7'd0});
    send_scores("zero", sc, NC, 1'b0);
    check_result("zero");
  endtask

  task automatic test_bubbles_restart();
    set_t part = '{7'd90, 7'd91, 7'd95, 7'd93, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0};
    set_t sc;
    do_start("restart");
    send_scores("restart_partial", part, 4, 1'b1);
    do_start("restart");
    for (int i = 0; i < NC - 1; i++) sc[i] = SW'($urandom_range(0, 59));
    sc[NC-1] = 7'd60;
    sb_q.push_back(model(sc));
    send_scores("restart_full", sc, NC, 1'b1);
    check_result("restart");
  endtask

  // start coinciding with the final score: the score is dropped, no DONE.
  task automatic test_start_on_last();
    set_t sc;
    for (int i = 0; i < NC; i++) sc[i] = SW'($urandom_range(0, 96));
    do_start("start_last");
    send_scores("start_last_partial", sc, NC - 1, 1'b0);
    score_valid = 1'b1;
    score_in    = 7'd96;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    score_valid = 1'b0;
    vectors++;
    if (out_en !== 1'b0 || score_ready !== 1'b1 || label_out !== 4'd0 || max_score !== 7'd0) begin
      miscompares++;
      $display("FAIL start_last: out_en/ready/label/max = %b/%b/%0d/%0d, required 0/1/0/0",
               out_en, score_ready, label_out, max_score);
    end
    sb_q.push_back(model(sc));
    send_scores("start_last_full", sc, NC, 1'b0);
    check_result("start_last");
  endtask

  task automatic test_protocol_err();
    set_t sc = '{7'd3, 7'd8, 7'd44, 7'd8, 7'd2, 7'd44, 7'd1, 7'd9, 7'd0, 7'd7};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    score_valid = 1'b1;
    score_in    = 7'd77;
    tick();
    score_valid = 1'b0;
    vectors++;
    if (err !== 1'b1 || out_en !== 1'b0 || label_out !== 4'd0 || score_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL err_idle: err/out_en/label/ready = %b/%b/%0d/%b, required 1/0/0/0",
               err, out_en, label_out, score_ready);
    end
    do_start("err_clear");
    sb_q.push_back('{lbl: 4'd2, mx: 7'd44});
    send_scores("err_set", sc, NC, 1'b0);
    score_valid = 1'b1;
    score_in    = 7'd95;
    tick();
    score_valid = 1'b0;
    vectors++;
    if (err !== 1'b1 || out_en !== 1'b1 || label_out !== 4'd2 || max_score !== 7'd44) begin
      miscompares++;
      $display("FAIL err_done: err/out_en/label/max = %b/%b/%0d/%0d, required 1/1/2/44",
               err, out_en, label_out, max_score);
    end
    check_result("err_done_hold");
    do_start("err_done_clear");
  endtask

  task automatic test_reset_mid();
    set_t sc = '{7'd11, 7'd22, 7'd33, 7'd44, 7'd55, 7'd66, 7'd0, 7'd0, 7'd0, 7'd0};
    do_start("rst_mid");
    send_scores("rst_mid", sc, 6, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_outputs("rst_mid");
    do_start("rst_start");
    send_scores("rst_start", sc, 3, 1'b0);
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check_idle_outputs("rst_and_start");
    tick();
    check_idle_outputs("rst_and_start_hold");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_zero();
    test_bubbles_restart();
    test_start_on_last();
    test_protocol_err();
    test_reset_mid();
    if (sb_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_bnn_argmax_out
